// File: rtl/apb_slv_pkg.sv
// ============================================================================
// Module   : apb_slv_pkg
// Purpose  : Shared types and helpers for the apb_slave_mem completer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Number of byte-offset address bits that sit below the word index.
  function automatic int byte_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  localparam int APB_DATA_WIDTH = 32;
  localparam int BYTE_LSB       = byte_lsb(APB_DATA_WIDTH);
  localparam int IDX_MAX_W      = 16;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 err;
  } dec_t;

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem_if.sv
// ============================================================================
// Module   : apb_slave_mem_if
// Purpose  : APB3 bus bundle between a requester and the apb_slave_mem completer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PSEL_WIDTH = 1
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [PSEL_WIDTH-1:0] psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output pready, prdata, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_slv_addr_dec.sv
// ============================================================================
// Module   : apb_slv_addr_dec
// Purpose  : Combinational byte address to word index / error decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slv_addr_dec
  import apb_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1000,
  parameter int                    DEPTH      = 16
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output dec_t                  dec
);

  localparam int                    LSB      = byte_lsb(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);

  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;

  always_comb begin
    w_off   = paddr - BASE_ADDR;
    w_word  = w_off >> LSB;
    dec.err = (paddr < BASE_ADDR) ||
              ((w_off & LSB_MASK) != '0) ||
              (w_word >= ADDR_WIDTH'(DEPTH));
    dec.idx = dec.err ? '0 : IDX_MAX_W'(w_word);
  end

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module   : apb_slave_mem
// Purpose  : APB3 completer with a DEPTH-word memory, optional wait states and
//            pslverr on out-of-range / misaligned access.
//            Build option: APB_SLV_WAIT_EN enables WAIT_CYCLES wait states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
  import apb_slv_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    PSEL_WIDTH  = 1,
  parameter int                    SEL_IDX     = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1000,
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_CYCLES = 2
) (
  input  logic           pclk,
  input  logic           preset,
  apb_slave_mem_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                r_state;
  dec_t                  r_dec;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  dec_t                  w_dec;
  dec_t                  w_cdec;
  logic                  w_cwrite;
  logic [DATA_WIDTH-1:0] w_cwdata;
  logic [IDX_W-1:0]      w_cidx;
  logic                  w_sel;
  logic                  w_setup;
  logic                  w_live;
  logic                  w_done_setup;
  logic                  w_done_acc;
  logic                  w_complete;

  apb_slv_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH      (DEPTH)
  ) u_dec (
    .paddr (bus.paddr),
    .dec   (w_dec)
  );

  assign w_sel   = bus.psel[SEL_IDX];
  assign w_setup = (r_state == IDLE) && w_sel && !bus.penable;
  assign w_live  = w_sel && bus.penable;

`ifdef APB_SLV_WAIT_EN
  localparam int W_EFF = WAIT_CYCLES;
  localparam int CNT_W = (W_EFF > 0) ? $clog2(W_EFF + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_cnt <= '0;
    end else if (w_setup) begin
      r_cnt <= CNT_W'(W_EFF);
    end else if (r_state == ACCESS && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_done_setup = w_setup && (W_EFF == 0);
  assign w_done_acc   = (r_state == ACCESS) && !r_pready && w_live && (r_cnt == CNT_W'(1));
`else
  assign w_done_setup = w_setup;
  assign w_done_acc   = 1'b0;
`endif

  assign w_complete = w_done_setup || w_done_acc;

  // A zero-wait transfer completes on the setup edge, so it commits from the
  // live bus; a waited one commits from the setup-latched copy.
  assign w_cdec   = (r_state == IDLE) ? w_dec       : r_dec;
  assign w_cwrite = (r_state == IDLE) ? bus.pwrite  : r_write;
  assign w_cwdata = (r_state == IDLE) ? bus.pwdata  : r_wdata;
  assign w_cidx   = IDX_W'(w_cdec.idx);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= IDLE;
      r_dec     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_dec   <= w_dec;
            r_write <= bus.pwrite;
            r_wdata <= bus.pwdata;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_pready) begin
            r_state   <= DONE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            if (!r_write) begin
              r_prdata <= '0;
            end
          end else if (!w_live) begin
            r_state <= IDLE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_complete) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_cdec.err;
        if (!w_cwrite) begin
          r_prdata <= w_cdec.err ? '0 : r_mem[w_cidx];
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_complete && w_cwrite && !w_cdec.err) begin
      r_mem[w_cidx] <= w_cwdata;
    end
  end

  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
  assign bus.prdata  = r_prdata;

endmodule

`default_nettype wire
